// File: rtl/b_channel_controller.sv
// AXI4 write-response (B) channel controller: per-slave in-order queues of issuing-master IDs,
// combinational routing of each slave's BRESP to its master, round-robin on master collisions.
module b_channel_controller #(
  parameter int unsigned Masters_Num    = 2,
  parameter int unsigned Num_Of_Slaves  = 2,
  parameter int unsigned Slaves_ID_Size = $clog2(Masters_Num),
  parameter int unsigned Queue_Depth    = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      AW_Push,
  input  logic [Slaves_ID_Size-1:0] AW_Master_ID,
  input  logic                      AW_Slave_Sel,
  output logic [Num_Of_Slaves-1:0]  Queue_Is_Full,
  output logic                      Unexpected_Resp,
  output logic                      Overflow_Err,
  input  logic [1:0]                M00_AXI_bresp,
  input  logic                      M00_AXI_bvalid,
  output logic                      M00_AXI_bready,
  input  logic [1:0]                M01_AXI_bresp,
  input  logic                      M01_AXI_bvalid,
  output logic                      M01_AXI_bready,
  output logic [1:0]                S00_AXI_bresp,
  output logic                      S00_AXI_bvalid,
  input  logic                      S00_AXI_bready,
  output logic [1:0]                S01_AXI_bresp,
  output logic                      S01_AXI_bvalid,
  input  logic                      S01_AXI_bready
);

  localparam int unsigned PtrW = $clog2(Queue_Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Queue_Depth);

  logic [Slaves_ID_Size-1:0] mem_q [Num_Of_Slaves][Queue_Depth];
  logic [Num_Of_Slaves-1:0][PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Num_Of_Slaves-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [Num_Of_Slaves-1:0]           full_q, full_d;
  logic prio_q, prio_d;
  logic unexp_q, unexp_d;
  logic ovf_q, ovf_d;

  logic [Num_Of_Slaves-1:0][1:0]                m_bresp;
  logic [Num_Of_Slaves-1:0]                     m_bvalid, m_bready;
  logic [Masters_Num-1:0][1:0]                  s_bresp;
  logic [Masters_Num-1:0]                       s_bvalid, s_bready;
  logic [Num_Of_Slaves-1:0][Slaves_ID_Size-1:0] head;
  logic [Num_Of_Slaves-1:0]                     req, grant, pop, push;
  logic                                         contest;

  assign m_bresp  = {M01_AXI_bresp, M00_AXI_bresp};
  assign m_bvalid = {M01_AXI_bvalid, M00_AXI_bvalid};
  assign s_bready = {S01_AXI_bready, S00_AXI_bready};

  // Routing and arbitration
  always_comb begin
    s_bvalid = '0;
    s_bresp  = '0;
    m_bready = '0;
    for (int k = 0; k < Num_Of_Slaves; k++) begin
      head[k] = mem_q[k][rptr_q[k]];
      req[k]  = m_bvalid[k] && (cnt_q[k] != '0);
    end
    contest = req[0] && req[1] && (head[0] == head[1]);
    for (int k = 0; k < Num_Of_Slaves; k++) begin
      grant[k] = req[k] && (!contest || (prio_q == 1'(k)));
      if (grant[k]) begin
        s_bvalid[head[k]] = 1'b1;
        s_bresp[head[k]]  = m_bresp[k];
        m_bready[k]       = s_bready[head[k]];
      end
    end
    pop = m_bvalid & m_bready;
  end

  // Queue bookkeeping and sticky error flags
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    prio_d  = prio_q;
    unexp_d = unexp_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < Num_Of_Slaves; k++) begin
      // A same-cycle pop frees the slot even when the queue is full
      push[k] = AW_Push && (AW_Slave_Sel == 1'(k)) && ((cnt_q[k] < FullCnt) || pop[k]);
      if (push[k]) wptr_d[k] = wptr_q[k] + 1'b1;
      if (pop[k])  rptr_d[k] = rptr_q[k] + 1'b1;
      if (push[k] && !pop[k])      cnt_d[k] = cnt_q[k] + 1'b1;
      else if (pop[k] && !push[k]) cnt_d[k] = cnt_q[k] - 1'b1;
      full_d[k] = (cnt_d[k] == FullCnt);
      if (m_bvalid[k] && (cnt_q[k] == '0)) unexp_d = 1'b1;
    end
    if (AW_Push && !(|push)) ovf_d = 1'b1;
    if (contest && pop[prio_q]) prio_d = ~prio_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= '0;
      prio_q  <= 1'b0;
      unexp_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      prio_q  <= prio_d;
      unexp_q <= unexp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them
  always_ff @(posedge ACLK) begin
    for (int k = 0; k < Num_Of_Slaves; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= AW_Master_ID;
    end
  end

  assign Queue_Is_Full   = full_q;
  assign Unexpected_Resp = unexp_q;
  assign Overflow_Err    = ovf_q;
  assign M00_AXI_bready  = m_bready[0];
  assign M01_AXI_bready  = m_bready[1];
  assign S00_AXI_bvalid  = s_bvalid[0];
  assign S01_AXI_bvalid  = s_bvalid[1];
  assign S00_AXI_bresp   = s_bresp[0];
  assign S01_AXI_bresp   = s_bresp[1];

endmodule
